imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the instruction memory, which the processor fetch path only reads. It accepts a byte stream over a valid/ready handshake, packs big-endian 32-bit words, and writes them to consecutive instruction-memory word addresses. While loading, it holds the processor in reset and releases it only after the last word is written. It sits beside the processor at the top level: its write port feeds the instruction memory, and its `cpu_reset` output is ORed into the processor `Reset`.

## Interface
- `ADDR_W`, default 6: instruction-memory word-address width. Depth is 2^ADDR_W words.
- `CLK` input, 1: clock; all state changes on its rising edge.
- `RESET` input, 1: asynchronous, active-high reset.
- `rx_valid` input, 1: `rx_byte` holds a valid byte.
- `rx_byte` input, 8: stream byte.
- `rx_ready` output, 1: loader can accept a byte. A byte transfers on a cycle where `rx_valid` and `rx_ready` are both 1.
- `imem_we` output, 1: one-cycle write strobe.
- `imem_addr` output, ADDR_W: word address.
- `imem_wdata` output, 32: word to write.
- `cpu_reset` output, 1: holds the processor in reset.
- `done` output, 1: load completed successfully. Sticky.
- `error` output, 1: load aborted. Sticky.

## Operation
- Stream format:
  - 16-bit word count N, high byte first.
  - N×4 data bytes, each word big-endian (first byte goes to [31:24]).
  - With `IMEM_LOADER_CHECKSUM_EN`, one checksum byte follows the data.
- States:
  - LEN_HI: accept count high byte; go to LEN_LO.
  - LEN_LO: accept count low byte, then:
    - N > 2^ADDR_W: go to ERR.
    - N = 0: go to CSUM if checksum is enabled, otherwise DONE.
    - Otherwise: go to DATA.
  - DATA: a 2-bit byte counter assembles a word. On the 4th byte, issue a write and increment the word counter. After the N-th word, go to CSUM or DONE.
  - CSUM: compare the received byte with the running XOR of all data bytes (the count bytes are excluded). Match: go to DONE. Mismatch: go to ERR.
  - DONE and ERR: terminal; only `RESET` leaves them.
- `rx_ready` = 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 in DONE and ERR, and while `RESET` is high.
- `cpu_reset` = 1 in every state except DONE.
- `error` = 1 only in ERR. In ERR, `cpu_reset` stays 1 and no further writes occur.
- Addresses start at 0, increment by 1 per word, and never wrap. A full-depth load ends at 2^ADDR_W−1.

## Timing
- Reset values: `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `done`=0, `error`=0.
- After reset: state is LEN_HI, and `rx_ready`=1 in the first cycle after `RESET` deasserts.
- Write latency:
  - `imem_we`, `imem_addr` and `imem_wdata` are registered.
  - The strobe is high for exactly one cycle, the cycle after the 4th byte of a word is accepted.
  - `rx_ready` does not drop around writes, so one byte per cycle is sustained.
- Completion timing:
  - DONE is entered one cycle after the final accepted byte.
  - `cpu_reset` falls, and `done` rises, one cycle after the last `imem_we` pulse. This guarantees the processor's first fetch sees written data.
  - For N=0, both change one cycle after DONE is entered.
- Idle cycles (`rx_valid`=0) stall the loader with all state held.
- `RESET` mid-operation: all outputs return to their reset values immediately (asynchronously). The partial word is discarded and the next load restarts at address 0.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CSUM state and 8-bit XOR accumulator are present.
  - A mismatch gives `error`=1 with `cpu_reset` held at 1.
- Not defined:
  - CSUM state and accumulator are absent.
  - DATA (or LEN_LO when N=0) goes straight to DONE.
  - The stream has no trailing byte.

## Structure
- Shared package `imem_loader_pkg`:
  - state encoding (LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR);
  - `LEN_W`=16;
  - `BYTES_PER_WORD`=4.
- Sub-module `imem_word_packer`: shift register plus 2-bit byte counter. Its inputs are byte and accept; its outputs are the packed word and a one-cycle word-complete pulse. The loader FSM owns addressing, counting, checksum and reset control.

## Test plan
- N=2, words 0x20080005 and 0x2009000A, no gaps: `imem_we` pulses at addr 0 and 1 with those data; `cpu_reset` falls and `done`=1 one cycle after the 2nd pulse.
- N=0 (checksum 0x00 if enabled): no `imem_we`; `done`=1 and `cpu_reset`=0.
- N=65 with ADDR_W=6: `error`=1 and `rx_ready`=0 after LEN_LO; `cpu_reset` stays 1; no writes.
- Checksum enabled, N=1, word 0x12345678:
  - checksum 0x08: write at addr 0, then `done`=1;
  - checksum 0x09: `error`=1 and `cpu_reset`=1.
- Random `rx_valid` gaps, with `RESET` pulsed after 6 data bytes: outputs return to reset values; the reload of N=1, 0xDEADBEEF writes addr 0.
- N=64, ADDR_W=6: the last write is at addr 63 with no wrap, then `done`=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes big-endian into 32-bit words; word_done marks the 4th byte.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_byte,
    input  logic        accept,
    output logic [31:0] word,
    output logic        word_done
);

    logic [23:0] shift;
    logic [1:0]  cnt;

    // The completed word includes the byte being accepted this cycle.
    assign word      = {shift, data_byte};
    assign word_done = accept && (cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift <= '0;
            cnt   <= '0;
        end else if (accept) begin
            shift <= {shift[15:0], data_byte};
            cnt   <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> instruction memory, holding the CPU in reset until loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// state  | meaning
// LEN_HI | waiting for word-count high byte
// LEN_LO | waiting for word-count low byte
// DATA   | receiving data bytes, writing one word per 4 bytes
// CSUM   | waiting for checksum byte (checksum build only)
// DONE   | load complete, CPU released one cycle later
// ERR    | load aborted, CPU held in reset
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);
    import imem_loader_pkg::*;

    localparam logic [LEN_W:0] DEPTH = (LEN_W + 1)'(2 ** ADDR_W);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CSUM;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t            state;
    logic [7:0]        len_hi;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  len_word;
    logic [ADDR_W:0]   word_cnt;
    logic              accept;
    logic              last_word;
    logic [31:0]       packed_word;
    logic              word_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_acc;
`endif

    assign rx_ready  = !RESET && (state == LEN_HI || state == LEN_LO ||
                                  state == DATA   || state == CSUM);
    assign accept    = rx_valid && rx_ready;
    assign len_word  = {len_hi, rx_byte};
    assign last_word = (LEN_W'(word_cnt) + LEN_W'(1)) == len;
    assign error     = (state == ERR);
    assign cpu_reset = !done;

    imem_word_packer u_packer (
        .clk       (CLK),
        .rst       (RESET),
        .data_byte (rx_byte),
        .accept    (accept && (state == DATA)),
        .word      (packed_word),
        .word_done (word_done)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= LEN_HI;
            len_hi     <= '0;
            len        <= '0;
            word_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_acc   <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            // Release lags DONE entry by one cycle so the final write has landed.
            done    <= (state == DONE);
            case (state)
                LEN_HI: if (accept) begin
                    len_hi <= rx_byte;
                    state  <= LEN_LO;
                end
                LEN_LO: if (accept) begin
                    len <= len_word;
                    if ({1'b0, len_word} > DEPTH)
                        state <= ERR;
                    else if (len_word == '0)
                        state <= END_STATE;
                    else
                        state <= DATA;
                end
                DATA: if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_acc <= csum_acc ^ rx_byte;
`endif
                    if (word_done) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_cnt[ADDR_W-1:0];
                        imem_wdata <= packed_word;
                        word_cnt   <= word_cnt + (ADDR_W + 1)'(1);
                        if (last_word)
                            state <= END_STATE;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: if (accept) begin
                    state <= (rx_byte == csum_acc) ? DONE : ERR;
                end
`endif
                DONE:    state <= DONE;
                ERR:     state <= ERR;
                default: state <= ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: stream-level reference model plus literal spot checks.
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic              CLK      = 1'b0;
    logic              RESET    = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_byte  = 8'h00;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: interprets the accepted byte index within the stream.
    int          m_cnt  = 0;
    int          m_n    = 0;
    int          m_term = 0;   // 0 running, 1 completed, 2 aborted
    logic [7:0]  m_hi   = 8'h00;
    logic [31:0] m_word = 32'h0;
    logic [7:0]  m_x    = 8'h00;
    logic        e_we   = 1'b0;
    logic        e_done = 1'b0;
    logic [5:0]  e_addr = 6'd0;
    logic [31:0] e_wdata = 32'h0;

    initial forever begin
        @(posedge CLK or posedge RESET);
        if (RESET) begin
            m_cnt = 0; m_n = 0; m_term = 0; m_hi = 0; m_word = 0; m_x = 0;
            e_we = 0; e_done = 0; e_addr = 0; e_wdata = 0;
        end else begin
            int k;
            logic [7:0] b;
            e_done = (m_term == 1);
            e_we   = 1'b0;
            if (rx_valid && m_term == 0) begin
                k = m_cnt;
                b = rx_byte;
                if (k == 0) begin
                    m_hi = b;
                end else if (k == 1) begin
                    m_n = int'({m_hi, b});
                    if (m_n > DEPTH) m_term = 2;
                    else if (m_n == 0 && !CS) m_term = 1;
                end else if (k < 2 + 4 * m_n) begin
                    m_word = {m_word[23:0], b};
                    m_x    = m_x ^ b;
                    if ((k - 2) % 4 == 3) begin
                        e_we    = 1'b1;
                        e_addr  = 6'((k - 2) / 4);
                        e_wdata = m_word;
                        if (k == 1 + 4 * m_n && !CS) m_term = 1;
                    end
                end else begin
                    m_term = (b == m_x) ? 1 : 2;
                end
                m_cnt++;
            end
        end
    end

    logic [5:0]  wq[$];
    logic [31:0] dq[$];

    initial forever begin
        @(negedge CLK);
        if (cmp_en) begin
            chk("rx_ready",   {31'b0, rx_ready},  {31'b0, (m_term == 0) && !RESET});
            chk("imem_we",    {31'b0, imem_we},   {31'b0, e_we});
            chk("imem_addr",  {26'b0, imem_addr}, {26'b0, e_addr});
            chk("imem_wdata", imem_wdata,         e_wdata);
            chk("done",       {31'b0, done},      {31'b0, e_done});
            chk("cpu_reset",  {31'b0, cpu_reset}, {31'b0, !e_done});
            chk("error",      {31'b0, error},     {31'b0, m_term == 2});
        end
        if (imem_we === 1'b1) begin
            wq.push_back(imem_addr);
            dq.push_back(imem_wdata);
        end
    end

    logic [7:0]  strm[$];
    logic [31:0] words[$];

    task automatic build(input int n);
        logic [7:0] x = 8'h00;
        strm.delete();
        strm.push_back(8'(n >> 8));
        strm.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int j = 3; j >= 0; j--) begin
                logic [7:0] b = 8'(words[i] >> (8 * j));
                strm.push_back(b);
                x = x ^ b;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        strm.push_back(x);
`endif
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic send(input int limit, input bit gaps);
        for (int i = 0; i < strm.size() && i < limit; i++) begin
            bit acc;
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int c = 0; c < g; c++) begin
                    @(negedge CLK);
                    rx_valid = 1'b0;
                end
            end
            @(negedge CLK);
            rx_valid = 1'b1;
            rx_byte  = strm[i];
            @(posedge CLK);
            acc = rx_ready;
            if (!acc) break;
        end
        @(negedge CLK);
        rx_valid = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge CLK);
        #2 RESET = 1'b1;
        rx_valid = 1'b0;
        #1;
        chk("async rx_ready",   {31'b0, rx_ready},  32'd0);
        chk("async imem_we",    {31'b0, imem_we},   32'd0);
        chk("async imem_wdata", imem_wdata,         32'd0);
        chk("async cpu_reset",  {31'b0, cpu_reset}, 32'd1);
        chk("async done",       {31'b0, done},      32'd0);
        chk("async error",      {31'b0, error},     32'd0);
        repeat (2) @(negedge CLK);
        #2 RESET = 1'b0;
        wq.delete();
        dq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        cmp_en = 1'b1;
        reset_dut();

        // Two words back to back
        words = '{32'h20080005, 32'h2009000A};
        build(2);
        send(1000, 1'b0);
        idle(4);
        chk("t1 writes", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("t1 addr0", {26'b0, wq[0]}, 32'd0);
            chk("t1 data0", dq[0], 32'h20080005);
            chk("t1 addr1", {26'b0, wq[1]}, 32'd1);
            chk("t1 data1", dq[1], 32'h2009000A);
        end
        chk("t1 done", {31'b0, done}, 32'd1);
        chk("t1 cpu_reset", {31'b0, cpu_reset}, 32'd0);

        // Empty program
        reset_dut();
        words.delete();
        build(0);
        send(1000, 1'b0);
        idle(4);
        chk("t2 writes", 32'(wq.size()), 32'd0);
        chk("t2 done", {31'b0, done}, 32'd1);
        chk("t2 cpu_reset", {31'b0, cpu_reset}, 32'd0);

        // Oversized count
        reset_dut();
        strm = '{8'h00, 8'h41, 8'h11, 8'h22, 8'h33, 8'h44};
        send(1000, 1'b0);
        idle(4);
        chk("t3 error", {31'b0, error}, 32'd1);
        chk("t3 rx_ready", {31'b0, rx_ready}, 32'd0);
        chk("t3 cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("t3 writes", 32'(wq.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        reset_dut();
        strm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send(1000, 1'b0);
        idle(4);
        chk("t4a writes", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) chk("t4a data0", dq[0], 32'h12345678);
        chk("t4a done", {31'b0, done}, 32'd1);

        reset_dut();
        strm = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send(1000, 1'b0);
        idle(4);
        chk("t4b error", {31'b0, error}, 32'd1);
        chk("t4b cpu_reset", {31'b0, cpu_reset}, 32'd1);
        chk("t4b done", {31'b0, done}, 32'd0);
`endif

        // Reset mid-load after 6 data bytes, then reload
        reset_dut();
        rand_words(2);
        build(2);
        send(8, 1'b1);
        reset_dut();
        words = '{32'hDEADBEEF};
        build(1);
        send(1000, 1'b1);
        idle(4);
        chk("t5 writes", 32'(wq.size()), 32'd1);
        if (wq.size() == 1) begin
            chk("t5 addr0", {26'b0, wq[0]}, 32'd0);
            chk("t5 data0", dq[0], 32'hDEADBEEF);
        end
        chk("t5 done", {31'b0, done}, 32'd1);

        // Full depth
        reset_dut();
        rand_words(64);
        build(64);
        send(1000, 1'b1);
        idle(4);
        chk("t6 writes", 32'(wq.size()), 32'd64);
        if (wq.size() == 64) begin
            chk("t6 last addr", {26'b0, wq[63]}, 32'd63);
            chk("t6 last data", dq[63], words[63]);
        end
        chk("t6 done", {31'b0, done}, 32'd1);

        // Random lengths, occasionally over the limit or truncated by reset
        for (int it = 0; it < 6; it++) begin
            int n = $urandom_range(0, 70);
            reset_dut();
            rand_words(n);
            build(n);
            if (CS && $urandom_range(0, 2) == 0) strm[strm.size() - 1] ^= 8'h5A;
            send((n > DEPTH) ? 2 : 1000, 1'b1);
            idle(4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
